// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: address out, word and ready back.
interface fetch_stage_if #(
   parameter int ADDRBITS = 16,
   parameter int INSTBITS = 16
);
   logic [ADDRBITS-1:0] imem_addr;
   logic [INSTBITS-1:0] imem_data;
   logic                imem_ready;

   modport master (output imem_addr, input imem_data, input imem_ready);
   modport slave  (input imem_addr, output imem_data, output imem_ready);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register. Priority of the
// per-cycle update: redirect > squash (full_noop) > hold (noop) > memory
// not ready > normal fetch. Every bubble placed in the slot is counted.
module fetch_stage #(
   parameter int                     ADDRBITS  = 16,
   parameter int                     INSTBITS  = 16,
   parameter int                     REGBITS   = 4,
   parameter logic [ADDRBITS-1:0]    RESET_PC  = '0,
   parameter logic [INSTBITS-1:0]    NOP_INSTR = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                noop,
   input  logic                full_noop,
   input  logic                redirect,
   input  logic [ADDRBITS-1:0] redirect_pc,
   fetch_stage_if.master       imem,
   output logic [INSTBITS-1:0] instr_D,
   output logic [REGBITS-1:0]  op_D,
   output logic [ADDRBITS-1:0] pc_D,
   output logic [ADDRBITS-1:0] pc_plus1_D,
   output logic                valid_D,
   output logic [15:0]         bubble_cnt
);

   logic [ADDRBITS-1:0] pc_q, pc_d;
   logic [INSTBITS-1:0] instr_q, instr_d;
   logic [ADDRBITS-1:0] pc_dec_q, pc_dec_d;
   logic                valid_q, valid_d;
   logic [15:0]         bubble_cnt_q, bubble_cnt_d;
   logic                bubble;

   // Next-state selection; the bubble fields use the PC before any redirect.
   always_comb begin
      pc_d         = pc_q;
      instr_d      = instr_q;
      pc_dec_d     = pc_dec_q;
      valid_d      = valid_q;
      bubble       = 1'b0;
      if (redirect) begin
         pc_d   = redirect_pc;
         bubble = 1'b1;
      end else if (full_noop) begin
         bubble = 1'b1;
      end else if (noop) begin
         bubble = 1'b0;
      end else if (!imem.imem_ready) begin
         bubble = 1'b1;
      end else begin
         instr_d  = imem.imem_data;
         pc_dec_d = pc_q;
         valid_d  = 1'b1;
         pc_d     = pc_q + 1'b1;
      end
      if (bubble) begin
         instr_d  = NOP_INSTR;
         pc_dec_d = pc_q;
         valid_d  = 1'b0;
      end
      bubble_cnt_d = bubble_cnt_q;
      if (bubble && (bubble_cnt_q != 16'hFFFF))
         bubble_cnt_d = bubble_cnt_q + 16'd1;
   end

   // PC, decode slot and bubble counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         instr_q      <= NOP_INSTR;
         pc_dec_q     <= '0;
         valid_q      <= 1'b0;
         bubble_cnt_q <= 16'd0;
      end else begin
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         pc_dec_q     <= pc_dec_d;
         valid_q      <= valid_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign imem.imem_addr = pc_q;
   assign instr_D        = instr_q;
   assign op_D           = instr_q[INSTBITS-1 -: REGBITS];
   assign pc_D           = pc_dec_q;
   assign pc_plus1_D     = pc_dec_q + 1'b1;
   assign valid_D        = valid_q;
   assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random control traffic
// against a reference model of the fetch/decode-slot rules; a second
// instance with a 4-bit PC covers address wrap and counter saturation.
module tb_fetch_stage;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- instance A: 16-bit PC ----------------
   logic        noop_a, full_a, redir_a, ready_a;
   logic [15:0] rpc_a;
   logic [15:0] instr_a, pcd_a, pcp1_a, cnt_a;
   logic [3:0]  op_a;
   logic        valid_a;

   fetch_stage_if #(.ADDRBITS(16), .INSTBITS(16)) if_a ();

   function automatic logic [15:0] mem_a(input logic [15:0] a);
      return (a == 16'h0005) ? 16'h7123 : 16'h1000 + a;
   endfunction

   assign if_a.imem_data  = mem_a(if_a.imem_addr);
   assign if_a.imem_ready = ready_a;

   fetch_stage #(.ADDRBITS(16), .INSTBITS(16), .REGBITS(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .noop(noop_a), .full_noop(full_a),
      .redirect(redir_a), .redirect_pc(rpc_a), .imem(if_a.master),
      .instr_D(instr_a), .op_D(op_a), .pc_D(pcd_a), .pc_plus1_D(pcp1_a),
      .valid_D(valid_a), .bubble_cnt(cnt_a)
   );

   // ---------------- instance B: 4-bit PC ----------------
   logic        ready_b;
   logic [3:0]  rpc_b;
   logic [15:0] instr_b, cnt_b;
   logic [3:0]  op_b, pcd_b, pcp1_b;
   logic        valid_b;

   fetch_stage_if #(.ADDRBITS(4), .INSTBITS(16)) if_b ();

   assign if_b.imem_data  = 16'h2000 + {12'h000, if_b.imem_addr};
   assign if_b.imem_ready = ready_b;

   fetch_stage #(.ADDRBITS(4), .INSTBITS(16), .REGBITS(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .noop(1'b0), .full_noop(1'b0),
      .redirect(1'b0), .redirect_pc(rpc_b), .imem(if_b.master),
      .instr_D(instr_b), .op_D(op_b), .pc_D(pcd_b), .pc_plus1_D(pcp1_b),
      .valid_D(valid_b), .bubble_cnt(cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model for instance A.
   logic [15:0] m_pc, m_instr, m_pcd, m_cnt;
   logic        m_v;

   task automatic model_reset();
      m_pc = 16'h0; m_instr = 16'h0; m_pcd = 16'h0; m_v = 1'b0; m_cnt = 16'h0;
   endtask

   task automatic model_step(input logic nz, input logic fn, input logic rd,
                             input logic [15:0] rpc, input logic rdy);
      logic bub;
      bub = rd || fn || (!nz && !rdy);
      if (!rd && !fn && !nz && rdy) begin
         m_instr = mem_a(m_pc);
         m_pcd   = m_pc;
         m_v     = 1'b1;
         m_pc    = m_pc + 16'd1;
      end
      if (bub) begin
         m_instr = 16'h0;
         m_pcd   = m_pc;
         m_v     = 1'b0;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (rd) m_pc = rpc;
   endtask

   task automatic check_a(input string tag);
      chk({tag, ".addr"},  {16'h0, if_a.imem_addr}, {16'h0, m_pc});
      chk({tag, ".instr"}, {16'h0, instr_a}, {16'h0, m_instr});
      chk({tag, ".op"},    {28'h0, op_a},    {28'h0, m_instr[15:12]});
      chk({tag, ".pc_D"},  {16'h0, pcd_a},   {16'h0, m_pcd});
      chk({tag, ".pcp1"},  {16'h0, pcp1_a},  {16'h0, m_pcd + 16'd1});
      chk({tag, ".valid"}, {31'h0, valid_a}, {31'h0, m_v});
      chk({tag, ".cnt"},   {16'h0, cnt_a},   {16'h0, m_cnt});
   endtask

   task automatic step_a(input string tag, input logic nz, input logic fn,
                         input logic rd, input logic [15:0] rpc, input logic rdy);
      noop_a = nz; full_a = fn; redir_a = rd; rpc_a = rpc; ready_a = rdy;
      @(posedge clk);
      #1;
      model_step(nz, fn, rd, rpc, rdy);
      check_a(tag);
   endtask

   initial begin
      int guard;
      rst_n = 1'b0;
      noop_a = 0; full_a = 0; redir_a = 0; rpc_a = 0; ready_a = 1;
      ready_b = 1; rpc_b = 0;
      model_reset();
      #1;
      check_a("reset");
      #2 rst_n = 1'b1;

      // T1: straight-line fetch
      for (int i = 0; i < 4; i++) step_a("t1", 0, 0, 0, 0, 1);
      chk("t1.instr_lit", {16'h0, instr_a}, 32'h1003);
      chk("t1.pcd_lit", {16'h0, pcd_a}, 32'h3);

      // T2: LW at pc 5 followed by a one-cycle hold
      step_a("t2a", 0, 0, 0, 0, 1);
      step_a("t2b", 0, 0, 0, 0, 1);
      step_a("t2hold", 1, 0, 0, 0, 1);
      chk("t2.instr_lit", {16'h0, instr_a}, 32'h7123);
      chk("t2.addr_lit", {16'h0, if_a.imem_addr}, 32'h6);
      step_a("t2next", 0, 0, 0, 0, 1);
      chk("t2.pcd_lit", {16'h0, pcd_a}, 32'h6);

      // T3: squash at pc 9, then refetch
      guard = 0;
      while (m_pc != 16'd9 && guard < 20) begin
         step_a("t3run", 0, 0, 0, 0, 1);
         guard++;
      end
      chk("t3.reach_pc9", {16'h0, if_a.imem_addr}, 32'h9);
      step_a("t3sq", 0, 1, 0, 0, 1);
      chk("t3.valid_lit", {31'h0, valid_a}, 32'h0);
      step_a("t3re", 0, 0, 0, 0, 1);
      chk("t3.pcd_lit", {16'h0, pcd_a}, 32'h9);

      // T4: redirect overriding a hold
      step_a("t4rd", 1, 0, 1, 16'h0040, 1);
      step_a("t4f", 0, 0, 0, 0, 1);
      chk("t4.instr_lit", {16'h0, instr_a}, 32'h1040);
      chk("t4.pcp1_lit", {16'h0, pcp1_a}, 32'h41);

      // T5: memory not ready for three cycles at pc 12
      step_a("t5rd", 0, 0, 1, 16'd12, 1);
      for (int i = 0; i < 3; i++) step_a("t5nr", 0, 0, 0, 0, 0);
      chk("t5.addr_lit", {16'h0, if_a.imem_addr}, 32'hC);
      step_a("t5go", 0, 0, 0, 0, 1);
      chk("t5.pcd_lit", {16'h0, pcd_a}, 32'hC);

      // Random control traffic
      for (int i = 0; i < 400; i++) begin
         step_a("rnd", ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10),
                ($urandom_range(0, 99) < 10), 16'($urandom), ($urandom_range(0, 99) < 80));
      end

      // Park A on hold (no state change) while B runs its long sequence.
      noop_a = 1; full_a = 0; redir_a = 0; ready_a = 1;

      // B was reset with A and has run with ready=1 since then; re-reset it.
      rst_n = 1'b0;
      model_reset();
      #1;
      check_a("reset2");
      chk("b.reset_addr", {28'h0, if_b.imem_addr}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      ready_b = 1;
      for (int i = 0; i < 16; i++) @(posedge clk);
      #1;
      chk("t6.pcd15", {28'h0, pcd_b}, 32'hF);
      chk("t6.pcp1_wrap", {28'h0, pcp1_b}, 32'h0);
      chk("t6.instr", {16'h0, instr_b}, 32'h200F);
      chk("t6.addr_wrap", {28'h0, if_b.imem_addr}, 32'h0);
      @(posedge clk); #1;
      chk("t6.pcd0", {28'h0, pcd_b}, 32'h0);
      ready_b = 0;
      for (int i = 0; i < 65540; i++) @(posedge clk);
      #1;
      chk("t6.cnt_sat", {16'h0, cnt_b}, 32'hFFFF);
      chk("t6.valid", {31'h0, valid_b}, 32'h0);
      @(posedge clk); #1;
      chk("t6.cnt_hold", {16'h0, cnt_b}, 32'hFFFF);
      check_a("parked");

      // Async reset mid-redirect: no clock edge between assert and check.
      noop_a = 0; redir_a = 1; rpc_a = 16'h0123;
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_a("async_rst");
      chk("t6.rst_cnt_b", {16'h0, cnt_b}, 32'h0);
      chk("t6.rst_addr_b", {28'h0, if_b.imem_addr}, 32'h0);
      chk("t6.rst_valid_b", {31'h0, valid_b}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      redir_a = 0;
      step_a("post_rst", 0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
